// File: rtl/lsu_mem_port.sv
// lsu_mem_port: byte/half/word load-store initiator for the word-addressed data_mem.
// Define LSU_ALIGN_CHECK_EN to enable the misaligned/illegal-size checks and the ERR state.
module lsu_mem_port #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [2:0] {
        IDLE, READ, WRITE, RESP
`ifdef LSU_ALIGN_CHECK_EN
        , ERR
`endif
    } state_t;

    state_t state, state_n;
    logic [ADDR_W+1:0] addr_q, addr_n;
    logic [1:0] size_q, size_n;
    logic we_q, uns_q;
    logic [31:0] wd_q, rd_q, lane, mask, merged, ld;
    logic [4:0] sh;

`ifdef LSU_ALIGN_CHECK_EN
    logic bad;
    assign size_n = req_size;
    assign addr_n = req_addr;
    assign bad = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    // without checking, oversize requests become words and low address bits are dropped
    assign size_n = (req_size == 2'b11) ? 2'b10 : req_size;
    assign addr_n = {req_addr[ADDR_W+1:2], req_addr[1] & (size_n != 2'b10), req_addr[0] & (size_n == 2'b00)};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            size_q <= '0;
            we_q   <= 1'b0;
            uns_q  <= 1'b0;
            wd_q   <= '0;
            rd_q   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                addr_q <= addr_n;
                size_q <= size_n;
                we_q   <= req_we;
                uns_q  <= req_unsigned;
                wd_q   <= req_wdata;
            end
            if (state == READ)
                rd_q <= mem_rdata;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:
`ifdef LSU_ALIGN_CHECK_EN
                if (req_valid) state_n = bad ? ERR : (req_we && size_n == 2'b10) ? WRITE : READ;
`else
                if (req_valid) state_n = (req_we && size_n == 2'b10) ? WRITE : READ;
`endif
            READ:    state_n = we_q ? WRITE : RESP;
            WRITE:   state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    assign sh     = {addr_q[1:0], 3'b000};
    assign lane   = rd_q >> sh;
    assign ld     = (size_q == 2'b00) ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
                    (size_q == 2'b01) ? {{16{~uns_q & lane[15]}}, lane[15:0]} : rd_q;
    assign mask   = (size_q == 2'b00) ? (32'h0000_00ff << sh) : (32'h0000_ffff << sh);
    assign merged = (size_q == 2'b10) ? wd_q : ((rd_q & ~mask) | ((wd_q << sh) & mask));

    assign req_ready = (state == IDLE);
    assign mem_write = (state == WRITE);
    assign mem_addr  = (state == READ || state == WRITE) ? addr_q[ADDR_W+1:2] : '0;
    assign mem_wdata = (state == WRITE) ? merged : '0;
    assign rsp_rdata = (state == RESP && !we_q) ? ld : '0;
`ifdef LSU_ALIGN_CHECK_EN
    assign rsp_valid = (state == RESP) || (state == ERR);
    assign rsp_err   = (state == ERR);
`else
    assign rsp_valid = (state == RESP);
    assign rsp_err   = 1'b0;
`endif
endmodule
